// File: rtl/uart_rx_if.sv
// Signal bundle between the UART receiver, the pad and the bus-side UART registers.
// master = pad/bus side driving line, tick and config; slave = the receiver itself.
interface uart_rx_if;
    logic       baudRateX16Tick;
    logic       uartRxD;
    logic       dataBits8;
    logic       parityEnable;
    logic       parityOdd;
    logic       twoStopBits;
    logic       rxReady;
    logic       clearOverrun;
    logic [7:0] rxData;
    logic       rxValid;
    logic       frameError;
    logic       parityError;
    logic       breakDetect;
    logic       overrun;

    modport master (
        output baudRateX16Tick, uartRxD, dataBits8, parityEnable, parityOdd,
               twoStopBits, rxReady, clearOverrun,
        input  rxData, rxValid, frameError, parityError, breakDetect, overrun
    );

    modport slave (
        input  baudRateX16Tick, uartRxD, dataBits8, parityEnable, parityOdd,
               twoStopBits, rxReady, clearOverrun,
        output rxData, rxValid, frameError, parityError, breakDetect, overrun
    );
endinterface

// File: rtl/uart_receiver.sv
// UART receive path: x16 oversampled deserialiser, parity/stop checks, one-entry holding register.
// Optional build macro UART_RX_MAJORITY_EN: each bit decided by a 2-of-3 vote around the sample point.
//
// state  | meaning
// IDLE   | waiting for a 1->0 edge on the synchronised line
// START  | confirming the start bit at its midpoint
// DATA   | shifting in 7 or 8 data bits, LSB first
// PARITY | sampling the parity bit
// STOP1  | sampling the first stop bit
// STOP2  | sampling the second stop bit
module uart_receiver #(
    parameter int SYNC_STAGES = 2
) (
    input logic      clock,
    input logic      resetN,
    uart_rx_if.slave rx_if
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

`ifdef UART_RX_MAJORITY_EN
    localparam logic [3:0] START_PT = 4'd8;
    localparam logic [3:0] BIT_PT   = 4'd0;
`else
    localparam logic [3:0] START_PT = 4'd7;
    localparam logic [3:0] BIT_PT   = 4'd15;
`endif

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   line_prev_q, line_prev_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [2:0]             idx_q, idx_d;
    logic [7:0]             shift_q, shift_d;
    logic                   cfg8_q, cfg8_d;
    logic                   cfg_pen_q, cfg_pen_d;
    logic                   cfg_odd_q, cfg_odd_d;
    logic                   cfg_two_q, cfg_two_d;
    logic                   fe_q, fe_d;
    logic                   pe_q, pe_d;
    logic                   par_bit_q, par_bit_d;
    logic                   stop1_q, stop1_d;
    logic [7:0]             data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   hold_fe_q, hold_fe_d;
    logic                   hold_pe_q, hold_pe_d;
    logic                   hold_brk_q, hold_brk_d;
    logic                   overrun_q, overrun_d;

    logic       rxd_s;
    logic       tick;
    logic       bit_val;
    logic       sample_now;
    logic [7:0] data_w;
    logic       done;
    logic       fin_fe;
    logic       fin_brk;
    logic       overrun_set;

    assign rxd_s  = sync_q[SYNC_STAGES-1];
    assign tick   = rx_if.baudRateX16Tick;
    // 7-bit frames leave the first bit at shift_q[1]; realign so bit 7 reads 0
    assign data_w = cfg8_q ? shift_q : {1'b0, shift_q[7:1]};

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] vote_q, vote_d;
    logic       armed_q, armed_d;

    assign bit_val = (vote_q[0] & vote_q[1]) | ((vote_q[0] | vote_q[1]) & rxd_s);
    // armed keeps the count-0 decision from firing on the tick right after START
    assign sample_now = tick && ((state_q == START) ? (cnt_q == START_PT)
                                                    : (armed_q && (cnt_q == BIT_PT)));

    always_comb begin
        vote_d  = vote_q;
        armed_d = armed_q;
        if (tick) begin
            if (state_q == START) begin
                if (cnt_q == 4'd6) vote_d[0] = rxd_s;
                if (cnt_q == 4'd7) vote_d[1] = rxd_s;
                armed_d = 1'b0;
            end else if (state_q != IDLE) begin
                if (cnt_q == 4'd14) begin
                    vote_d[0] = rxd_s;
                    armed_d   = 1'b1;
                end
                if (cnt_q == 4'd15) vote_d[1] = rxd_s;
                if (cnt_q == BIT_PT) armed_d = 1'b0;
            end
        end
    end
`else
    assign bit_val    = rxd_s;
    assign sample_now = tick && (cnt_q == ((state_q == START) ? START_PT : BIT_PT));
`endif

    always_comb begin
        state_d     = state_q;
        sync_d      = {sync_q[SYNC_STAGES-2:0], rx_if.uartRxD};
        line_prev_d = rxd_s;
        cnt_d       = tick ? cnt_q + 4'd1 : cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        cfg8_d      = cfg8_q;
        cfg_pen_d   = cfg_pen_q;
        cfg_odd_d   = cfg_odd_q;
        cfg_two_d   = cfg_two_q;
        fe_d        = fe_q;
        pe_d        = pe_q;
        par_bit_d   = par_bit_q;
        stop1_d     = stop1_q;
        done        = 1'b0;
        fin_fe      = fe_q;
        fin_brk     = 1'b0;

        case (state_q)
            IDLE: begin
                if (line_prev_q && !rxd_s) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (sample_now) begin
                    if (bit_val) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        cnt_d     = '0;
                        idx_d     = '0;
                        cfg8_d    = rx_if.dataBits8;
                        cfg_pen_d = rx_if.parityEnable;
                        cfg_odd_d = rx_if.parityOdd;
                        cfg_two_d = rx_if.twoStopBits;
                        fe_d      = 1'b0;
                        pe_d      = 1'b0;
                        par_bit_d = 1'b0;
                    end
                end
            end
            DATA: begin
                if (sample_now) begin
                    shift_d = {bit_val, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == (cfg8_q ? 3'd7 : 3'd6)) begin
                        state_d = cfg_pen_q ? PARITY : STOP1;
                    end
                end
            end
            PARITY: begin
                if (sample_now) begin
                    par_bit_d = bit_val;
                    pe_d      = ((^data_w) ^ bit_val) != cfg_odd_q;
                    state_d   = STOP1;
                end
            end
            STOP1: begin
                if (sample_now) begin
                    stop1_d = bit_val;
                    fe_d    = ~bit_val;
                    if (cfg_two_q) begin
                        state_d = STOP2;
                    end else begin
                        done    = 1'b1;
                        fin_fe  = ~bit_val;
                        fin_brk = (data_w == 8'd0) && !bit_val && !par_bit_q;
                        state_d = IDLE;
                    end
                end
            end
            STOP2: begin
                if (sample_now) begin
                    done    = 1'b1;
                    fin_fe  = fe_q | ~bit_val;
                    fin_brk = (data_w == 8'd0) && !stop1_q && !par_bit_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        data_d      = data_q;
        valid_d     = valid_q;
        hold_fe_d   = hold_fe_q;
        hold_pe_d   = hold_pe_q;
        hold_brk_d  = hold_brk_q;
        overrun_set = 1'b0;
        if (valid_q && rx_if.rxReady) valid_d = 1'b0;
        // A frame that completes while the consumer is being served replaces the old one
        if (done) begin
            if (valid_q && !rx_if.rxReady) begin
                overrun_set = 1'b1;
            end else begin
                data_d     = data_w;
                valid_d    = 1'b1;
                hold_fe_d  = fin_fe;
                hold_pe_d  = pe_q;
                hold_brk_d = fin_brk;
            end
        end
        overrun_d = overrun_set | (overrun_q & ~rx_if.clearOverrun);
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q     <= IDLE;
            sync_q      <= '1;
            line_prev_q <= 1'b1;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            cfg8_q      <= 1'b0;
            cfg_pen_q   <= 1'b0;
            cfg_odd_q   <= 1'b0;
            cfg_two_q   <= 1'b0;
            fe_q        <= 1'b0;
            pe_q        <= 1'b0;
            par_bit_q   <= 1'b0;
            stop1_q     <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            hold_fe_q   <= 1'b0;
            hold_pe_q   <= 1'b0;
            hold_brk_q  <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
            vote_q      <= '1;
            armed_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            line_prev_q <= line_prev_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            cfg8_q      <= cfg8_d;
            cfg_pen_q   <= cfg_pen_d;
            cfg_odd_q   <= cfg_odd_d;
            cfg_two_q   <= cfg_two_d;
            fe_q        <= fe_d;
            pe_q        <= pe_d;
            par_bit_q   <= par_bit_d;
            stop1_q     <= stop1_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            hold_fe_q   <= hold_fe_d;
            hold_pe_q   <= hold_pe_d;
            hold_brk_q  <= hold_brk_d;
            overrun_q   <= overrun_d;
`ifdef UART_RX_MAJORITY_EN
            vote_q      <= vote_d;
            armed_q     <= armed_d;
`endif
        end
    end

    assign rx_if.rxData      = data_q;
    assign rx_if.rxValid     = valid_q;
    assign rx_if.frameError  = hold_fe_q;
    assign rx_if.parityError = hold_pe_q;
    assign rx_if.breakDetect = hold_brk_q;
    assign rx_if.overrun     = overrun_q;
endmodule
